// File: rtl/doc_write_ctrl.sv
// Write-side cursor/RAM controller for the 20x15 character document.
// Optional: define CLEAR_ON_RESET_EN to blank the screen after reset.
module doc_write_ctrl #(
  parameter int          COLS  = 20,
  parameter int          ROWS  = 15,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic [8:0] doc_a,
  output logic [7:0] doc_d,
  output logic       doc_we,
  output logic [4:0] cursor_col,
  output logic [3:0] cursor_row,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR
  } state_t;

  localparam logic [4:0] COL_MAX  = 5'(COLS - 1);
  localparam logic [3:0] ROW_MAX  = 4'(ROWS - 1);
  localparam logic [8:0] CELL_MAX = 9'(COLS * ROWS - 1);

  state_t     state_q, state_d;
  logic [8:0] a_d;
  logic [7:0] d_d;
  logic       we_d;
  logic       busy_d;
  logic [4:0] col_d;
  logic [3:0] row_d;
  logic [8:0] cur_a;
  logic       xfer;
  logic       is_print;
  logic       is_bs;
  logic       is_nl;
  logic       is_ff;
  logic       init_q;

`ifdef CLEAR_ON_RESET_EN
  // High only during the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) init_q <= 1'b1;
    else      init_q <= 1'b0;
  end
`else
  assign init_q = 1'b0;
`endif

  assign char_ready = (state_q == S_IDLE) && rst && !init_q;
  assign xfer       = char_valid && char_ready;

  assign cur_a = {5'd0, cursor_row} * 9'(COLS)
               + {4'd0, cursor_col};

  assign is_print = (char_data >= 8'h20)
                 && (char_data <= 8'h7e);
  assign is_bs    = (char_data == 8'h08);
  assign is_nl    = (char_data == 8'h0d);
  assign is_ff    = (char_data == 8'h0c);

  always_comb begin
    state_d = state_q;
    a_d     = doc_a;
    d_d     = doc_d;
    we_d    = 1'b0;
    busy_d  = busy;
    col_d   = cursor_col;
    row_d   = cursor_row;
    unique case (state_q)
      S_IDLE: begin
        if (init_q) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          a_d     = 9'd0;
          d_d     = BLANK;
        end else if (xfer) begin
          unique case (1'b1)
            is_print: begin
              state_d = S_WRITE;
              we_d    = 1'b1;
              a_d     = cur_a;
              d_d     = char_data;
              if (cursor_col == COL_MAX) begin
                col_d = 5'd0;
                row_d = (cursor_row == ROW_MAX)
                      ? 4'd0 : cursor_row + 4'd1;
              end else begin
                col_d = cursor_col + 5'd1;
              end
            end
            is_bs: begin
              // Row-major layout: previous cell is always cur_a-1.
              if (cursor_col != 5'd0 || cursor_row != 4'd0) begin
                state_d = S_WRITE;
                we_d    = 1'b1;
                a_d     = cur_a - 9'd1;
                d_d     = BLANK;
                if (cursor_col != 5'd0) begin
                  col_d = cursor_col - 5'd1;
                end else begin
                  col_d = COL_MAX;
                  row_d = cursor_row - 4'd1;
                end
              end
            end
            is_nl: begin
              col_d = 5'd0;
              row_d = (cursor_row == ROW_MAX)
                    ? 4'd0 : cursor_row + 4'd1;
            end
            is_ff: begin
              state_d = S_CLEAR;
              busy_d  = 1'b1;
              we_d    = 1'b1;
              a_d     = 9'd0;
              d_d     = BLANK;
            end
            default: begin
            end
          endcase
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (doc_a == CELL_MAX) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          col_d   = 5'd0;
          row_d   = 4'd0;
        end else begin
          we_d = 1'b1;
          a_d  = doc_a + 9'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      doc_a      <= 9'd0;
      doc_d      <= 8'd0;
      doc_we     <= 1'b0;
      busy       <= 1'b0;
      cursor_col <= 5'd0;
      cursor_row <= 4'd0;
    end else begin
      state_q    <= state_d;
      doc_a      <= a_d;
      doc_d      <= d_d;
      doc_we     <= we_d;
      busy       <= busy_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
    end
  end

endmodule

// File: tb/tb_doc_write_ctrl.sv
// Bench for doc_write_ctrl: directed steps plus random bytes
// checked against a linear-position document model.
module tb_doc_write_ctrl;

  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int CELLS = COLS * ROWS;

  logic       clk;
  logic       rst;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic [8:0] doc_a;
  logic [7:0] doc_d;
  logic       doc_we;
  logic [4:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int pos   = 0;

  doc_write_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .doc_a      (doc_a),
    .doc_d      (doc_d),
    .doc_we     (doc_we),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_col"}, 32'(cursor_col), 32'(pos % COLS));
    chk({tag, "_row"}, 32'(cursor_row), 32'(pos / COLS));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    char_valid = 1'b0;
    #2;
    chk("rst_we", 32'(doc_we), 32'd0);
    chk("rst_rdy", 32'(char_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pos = 0;
    @(negedge clk);
    chk("rst_rel_rdy", 32'(char_ready), 32'd1);
    chk_cursor("rst_rel");
  endtask

  // Offer one byte, wait for acceptance, check the response.
  // Entered and left on a falling edge.
  task automatic send(input logic [7:0] b,
                      input bit hold,
                      input logic [7:0] nxt);
    int n;
    int wa;
    bit w;
    bit clr;
    w = 0; wa = 0; clr = 0;
    if (b >= 8'h20 && b <= 8'h7e) begin
      w = 1; wa = pos; pos = (pos + 1) % CELLS;
    end else if (b == 8'h08) begin
      if (pos > 0) begin
        pos = pos - 1; w = 1; wa = pos;
      end
    end else if (b == 8'h0d) begin
      pos = ((pos / COLS + 1) % ROWS) * COLS;
    end else if (b == 8'h0c) begin
      clr = 1;
    end
    char_valid = 1'b1;
    char_data  = b;
    n = 0;
    while (char_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 1000), 32'd1);
    if (n >= 1000) begin
      char_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (hold) char_data = nxt;
    else char_valid = 1'b0;
    if (clr) begin
      for (int i = 0; i < CELLS; i++) begin
        chk("clr_ctl", 32'({doc_we, busy, char_ready}), 32'b110);
        chk("clr_a", 32'(doc_a), 32'(i));
        chk("clr_d", 32'(doc_d), 32'h20);
        @(negedge clk);
      end
      pos = 0;
      chk("clr_end", 32'({doc_we, busy, char_ready}), 32'b001);
      chk_cursor("clr_end");
    end else if (w) begin
      chk("wr_we", 32'(doc_we), 32'd1);
      chk("wr_a", 32'(doc_a), 32'(wa));
      chk("wr_d", 32'(doc_d), (b == 8'h08) ? 32'h20 : 32'(b));
      chk("wr_rdy", 32'(char_ready), 32'd0);
      chk_cursor("wr");
      @(negedge clk);
      chk("wr_done", 32'({doc_we, char_ready}), 32'b01);
    end else begin
      chk("nw_ctl", 32'({doc_we, busy, char_ready}), 32'b001);
      chk_cursor("nw");
    end
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] b;
    rst = 1'b0;
    char_valid = 1'b0;
    char_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'(doc_a), 32'd0);
    chk("rst_d", 32'(doc_d), 32'd0);
    chk("rst_we", 32'(doc_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(char_ready), 32'd0);
    chk("rst_cur", 32'({cursor_col, cursor_row}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 32'(char_ready), 32'd1);

    send(8'h41, 0, 8'h00);
    chk("a_cur", 32'({cursor_col, cursor_row}), 32'({5'd1, 4'd0}));

    do_reset();
    for (int i = 8'h30; i <= 8'h43; i++) send(8'(i), 0, 8'h00);
    chk("row_end", 32'({cursor_col, cursor_row}), 32'({5'd0, 4'd1}));
    send(8'h08, 0, 8'h00);
    chk("bs_wrap", 32'({cursor_col, cursor_row}), 32'({5'd19, 4'd0}));

    do_reset();
    send(8'h08, 0, 8'h00);

    repeat (14) send(8'h0d, 0, 8'h00);
    repeat (5) send(8'h78, 0, 8'h00);
    chk("at_5_14", 32'({cursor_col, cursor_row}), 32'({5'd5, 4'd14}));
    send(8'h0d, 0, 8'h00);
    repeat (14) send(8'h0d, 0, 8'h00);
    repeat (19) send(8'h79, 0, 8'h00);
    send(8'h5a, 0, 8'h00);
    chk("z_wrap", 32'({cursor_col, cursor_row}), 32'd0);

    send(8'h71, 0, 8'h00);
    send(8'h0c, 1, 8'h42);
    send(8'h42, 0, 8'h00);

    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) b = 8'($urandom_range(8'h20, 8'h7e));
      else if (r < 82) b = 8'h08;
      else if (r < 90) b = 8'h0d;
      else if (r < 98) begin
        b = 8'($urandom_range(0, 255));
        if ((b >= 8'h20 && b <= 8'h7e) || b == 8'h08
            || b == 8'h0d || b == 8'h0c) b = 8'h7f;
      end else b = 8'h0c;
      send(b, 0, 8'h00);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          chk("gap_we", 32'(doc_we), 32'd0);
        end
      end
    end

    send(8'h51, 0, 8'h00);
    char_valid = 1'b1;
    char_data = 8'h0c;
    n = 0;
    while (char_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    char_valid = 1'b0;
    n = 0;
    while (doc_a !== 9'd150 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_150", 32'(n < 400), 32'd1);
    chk("mid_busy", 32'({busy, doc_we}), 32'b11);
    chk_cursor("mid_clr");
    #2 rst = 1'b0;
    #1;
    chk("ab_a", 32'(doc_a), 32'd0);
    chk("ab_d", 32'(doc_d), 32'd0);
    chk("ab_ctl", 32'({doc_we, busy, char_ready}), 32'b000);
    chk("ab_cur", 32'({cursor_col, cursor_row}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pos = 0;
    @(negedge clk);
    chk("post_rdy", 32'({char_ready, busy, doc_we}), 32'b100);
    @(negedge clk);
    chk("post_idle", 32'({char_ready, busy, doc_we}), 32'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
